// File: rtl/lbdr_pkg.sv
// lbdr_pkg: flit codes, port indices, FSM states and deroute port codes shared by the LBDR router.
package lbdr_pkg;
  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] BODY   = 3'b010;
  localparam logic [2:0] TAIL   = 3'b100;
  localparam int P_N = 0;
  localparam int P_E = 1;
  localparam int P_W = 2;
  localparam int P_S = 3;
  localparam int P_L = 4;
  typedef enum logic [1:0] {IDLE, ROUTE, DROP} lbdr_state_t;
  typedef enum logic [1:0] {PC_N, PC_E, PC_W, PC_S} lbdr_port_code_t;
endpackage

// File: rtl/lbdr_route_calc.sv
// lbdr_route_calc: combinational LBDR decode to a one-hot {L,S,W,E,N} request; LBDR_DEROUTE_EN adds deroute.
module lbdr_route_calc
  import lbdr_pkg::*;
#(
  parameter int COORD_W = 2
) (
  input  logic [2*COORD_W-1:0] cur_i,
  input  logic [2*COORD_W-1:0] dst_i,
  input  logic [7:0]           rxy_i,
  input  logic [3:0]           cx_i,
`ifdef LBDR_DEROUTE_EN
  input  logic [7:0]           dr_i,
`endif
  output logic [4:0]           req_o
);
  logic [COORD_W-1:0] x_cur, y_cur, x_dst, y_dst;
  logic n1, s1, e1, w1, n, e, w, s, l;
  logic [4:0] min_req;
  assign {y_cur, x_cur} = cur_i;
  assign {y_dst, x_dst} = dst_i;
  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;
  assign n = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_i[0]) | (n1 & w1 & rxy_i[1])) & cx_i[P_N];
  assign e = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_i[2]) | (e1 & s1 & rxy_i[3])) & cx_i[P_E];
  assign w = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_i[4]) | (w1 & s1 & rxy_i[5])) & cx_i[P_W];
  assign s = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_i[6]) | (s1 & w1 & rxy_i[7])) & cx_i[P_S];
  assign l = ~n1 & ~e1 & ~w1 & ~s1;
  assign min_req = n ? 5'b00001 : e ? 5'b00010 : w ? 5'b00100 : s ? 5'b01000 : l ? 5'b10000 : 5'b00000;
`ifdef LBDR_DEROUTE_EN
  logic [1:0] prim, code;
  assign prim = n1 ? 2'(P_N) : s1 ? 2'(P_S) : e1 ? 2'(P_E) : 2'(P_W);
  assign code = dr_i[2*prim +: 2];
  assign req_o = |min_req ? min_req : (~l & cx_i[code]) ? 5'(5'd1 << code) : 5'b00000;
`else
  assign req_o = min_req;
`endif
endmodule

// File: rtl/lbdr_router.sv
// lbdr_router: per-input-port LBDR routing with packet hold, drop path and config registers; LBDR_DEROUTE_EN adds deroute.
module lbdr_router
  import lbdr_pkg::*;
#(
  parameter int                   COORD_W = 2,
  parameter logic [7:0]           RXY_RST = 8'h3C,
  parameter logic [3:0]           CX_RST  = 4'hF,
  parameter logic [2*COORD_W-1:0] CUR_RST = (2*COORD_W)'(5)
`ifdef LBDR_DEROUTE_EN
  , parameter logic [7:0]         DR_RST  = 8'h00
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [7:0]             cfg_rxy,
  input  logic [3:0]             cfg_cx,
  input  logic [2*COORD_W-1:0]   cfg_cur,
`ifdef LBDR_DEROUTE_EN
  input  logic [7:0]             cfg_dr,
`endif
  output logic                   cfg_busy,
  input  logic                   flit_valid,
  input  logic [2:0]             flit_id,
  input  logic [2*COORD_W-1:0]   dst_addr,
  input  logic                   flit_pop,
  output logic [4:0]             port_req,
  output logic                   drop,
  output logic                   proto_err
);
  lbdr_state_t state_q, state_d;
  logic [4:0] req_q, req_d, calc_req;
  logic drop_q, drop_d, err_q, err_d, hdr, tail_pop;
  logic [7:0] rxy_q;
  logic [3:0] cx_q;
  logic [2*COORD_W-1:0] cur_q;
`ifdef LBDR_DEROUTE_EN
  logic [7:0] dr_q;
`endif
  assign hdr      = flit_valid && flit_id == HEADER;
  assign tail_pop = flit_valid && flit_pop && flit_id == TAIL;
  lbdr_route_calc #(.COORD_W(COORD_W)) u_calc (
    .cur_i (cur_q),
    .dst_i (dst_addr),
    .rxy_i (rxy_q),
    .cx_i  (cx_q),
`ifdef LBDR_DEROUTE_EN
    .dr_i  (dr_q),
`endif
    .req_o (calc_req)
  );
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    drop_d  = drop_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (flit_valid) begin
        if (!hdr) err_d = 1'b1;
        else if (|calc_req) begin
          state_d = ROUTE;
          req_d   = calc_req;
        end else begin
          state_d = DROP;
          drop_d  = 1'b1;
        end
      end
      ROUTE: begin
        err_d = hdr;
        if (tail_pop) begin
          state_d = IDLE;
          req_d   = 5'b00000;
        end
      end
      default: if (tail_pop) begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 5'b00000;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end
  // Decode above reads the old registers, so a same-cycle header uses the previous configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxy_q <= RXY_RST;
      cx_q  <= CX_RST;
      cur_q <= CUR_RST;
`ifdef LBDR_DEROUTE_EN
      dr_q  <= DR_RST;
`endif
    end else if (cfg_we && state_q == IDLE) begin
      rxy_q <= cfg_rxy;
      cx_q  <= cfg_cx;
      cur_q <= cfg_cur;
`ifdef LBDR_DEROUTE_EN
      dr_q  <= cfg_dr;
`endif
    end
  end
  assign cfg_busy  = state_q != IDLE;
  assign port_req  = req_q;
  assign drop      = drop_q;
  assign proto_err = err_q;
endmodule

// File: tb/tb_lbdr_router.sv
// tb_lbdr_router: directed plus randomized checks of lbdr_router against a behavioural routing model.
module tb_lbdr_router;
  import lbdr_pkg::*;
  logic clk = 1'b0;
  logic rst, cfg_we, flit_valid, flit_pop, cfg_busy, drop, proto_err;
  logic [7:0] cfg_rxy, cfg_dr;
  logic [3:0] cfg_cx, cfg_cur, dst_addr;
  logic [2:0] flit_id;
  logic [4:0] port_req;
  int total = 0;
  int bad = 0;
  int m_mode;
  logic [4:0] m_req;
  logic m_drop, m_err;
  logic [7:0] m_rxy, m_dr;
  logic [3:0] m_cx, m_cur;
  always #5 clk = ~clk;
  lbdr_router dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx), .cfg_cur(cfg_cur),
`ifdef LBDR_DEROUTE_EN
    .cfg_dr(cfg_dr),
`endif
    .cfg_busy(cfg_busy), .flit_valid(flit_valid), .flit_id(flit_id), .dst_addr(dst_addr),
    .flit_pop(flit_pop), .port_req(port_req), .drop(drop), .proto_err(proto_err)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Route from signed hop distances: y grows southward, x grows eastward.
  function automatic logic [4:0] ref_route(input logic [3:0] cur, input logic [3:0] dst,
                                           input logic [7:0] rxy, input logic [3:0] cx, input logic [7:0] dr);
    int ddx, ddy;
    bit ok [4];
    int prim;
    logic [1:0] code;
    ddx = int'(dst[1:0]) - int'(cur[1:0]);
    ddy = int'(dst[3:2]) - int'(cur[3:2]);
    if (ddx == 0 && ddy == 0) return 5'b10000;
    ok[0] = ddy < 0 && (ddx == 0 || (ddx > 0 ? rxy[0] : rxy[1])) && cx[0];
    ok[1] = ddx > 0 && (ddy == 0 || (ddy < 0 ? rxy[2] : rxy[3])) && cx[1];
    ok[2] = ddx < 0 && (ddy == 0 || (ddy < 0 ? rxy[4] : rxy[5])) && cx[2];
    ok[3] = ddy > 0 && (ddx == 0 || (ddx > 0 ? rxy[6] : rxy[7])) && cx[3];
    for (int i = 0; i < 4; i++) if (ok[i]) return 5'(1 << i);
    prim = ddy < 0 ? 0 : ddy > 0 ? 3 : ddx > 0 ? 1 : 2;
    code = dr[2*prim +: 2];
`ifdef LBDR_DEROUTE_EN
    return cx[code] ? 5'(1 << code) : 5'b00000;
`else
    return 5'b00000;
`endif
  endfunction
  task automatic step(input bit r, input bit v, input logic [2:0] id, input logic [3:0] dst,
                      input bit pop, input bit we);
    logic [4:0] rr;
    bit idle_before;
    rst = r; flit_valid = v; flit_id = id; dst_addr = dst; flit_pop = pop; cfg_we = we;
    if (r) begin
      m_mode = 0; m_req = 0; m_drop = 0; m_err = 0;
      m_rxy = 8'h3C; m_cx = 4'hF; m_cur = 4'd5; m_dr = 8'h00;
    end else begin
      rr = ref_route(m_cur, dst, m_rxy, m_cx, m_dr);
      idle_before = m_mode == 0;
      m_err = 0;
      if (m_mode == 0) begin
        if (v && id == HEADER) begin
          if (rr != 0) begin m_mode = 1; m_req = rr; end
          else begin m_mode = 2; m_drop = 1; end
        end else if (v) m_err = 1;
      end else begin
        if (m_mode == 1 && v && id == HEADER) m_err = 1;
        if (v && pop && id == TAIL) begin m_mode = 0; m_req = 0; m_drop = 0; end
      end
      if (we && idle_before) begin
        m_rxy = cfg_rxy; m_cx = cfg_cx; m_cur = cfg_cur; m_dr = cfg_dr;
      end
    end
    @(negedge clk);
    check("port_req", 8'(port_req), 8'(m_req));
    check("drop", 8'(drop), 8'(m_drop));
    check("proto_err", 8'(proto_err), 8'(m_err));
    check("cfg_busy", 8'(cfg_busy), 8'(m_mode != 0));
  endtask
  initial begin
    int k;
    logic [2:0] id;
    cfg_rxy = 8'h3C; cfg_cx = 4'hF; cfg_cur = 4'd5; cfg_dr = 8'h00;
    step(1, 0, 3'b000, 0, 0, 0);
    step(1, 0, 3'b000, 0, 0, 0);
    check("rst_req", 8'(port_req), 8'h00);
    check("rst_busy", 8'(cfg_busy), 8'h00);
    step(0, 1, HEADER, 4'd6, 0, 0);
    check("hdr_E", 8'(port_req), 8'h02);
    step(0, 1, BODY, 4'd6, 1, 0);
    check("body_hold_E", 8'(port_req), 8'h02);
    step(0, 1, TAIL, 4'd6, 1, 0);
    check("tail_clear", 8'(port_req), 8'h00);
    step(0, 1, HEADER, 4'd5, 0, 0);
    check("local", 8'(port_req), 8'h10);
    step(0, 1, TAIL, 4'd5, 1, 0);
    cfg_rxy = 8'h3E;
    step(0, 0, 3'b000, 0, 0, 1);
    step(0, 1, HEADER, 4'd0, 0, 0);
    check("turn_N", 8'(port_req), 8'h01);
    step(0, 1, TAIL, 4'd0, 1, 0);
    cfg_rxy = 8'h3C; cfg_cx = 4'b1101;
    step(0, 0, 3'b000, 0, 0, 1);
    step(0, 1, HEADER, 4'd6, 0, 0);
`ifndef LBDR_DEROUTE_EN
    check("unroutable_drop", 8'(drop), 8'h01);
    check("unroutable_req", 8'(port_req), 8'h00);
`endif
    step(0, 1, TAIL, 4'd6, 1, 0);
    check("drop_exit", 8'(drop), 8'h00);
`ifdef LBDR_DEROUTE_EN
    cfg_dr = 8'h0C;
    step(0, 0, 3'b000, 0, 0, 1);
    step(0, 1, HEADER, 4'd6, 0, 0);
    check("deroute_S", 8'(port_req), 8'h08);
    step(0, 1, TAIL, 4'd6, 1, 0);
`endif
    cfg_cx = 4'hF; cfg_dr = 8'h00;
    step(0, 0, 3'b000, 0, 0, 1);
    step(0, 1, BODY, 4'd0, 1, 0);
    check("idle_body_err", 8'(proto_err), 8'h01);
    check("idle_body_busy", 8'(cfg_busy), 8'h00);
    step(0, 0, 3'b000, 0, 0, 0);
    check("err_pulse_end", 8'(proto_err), 8'h00);
    step(0, 1, HEADER, 4'd6, 0, 0);
    step(0, 1, HEADER, 4'd0, 0, 0);
    check("route_hdr_err", 8'(proto_err), 8'h01);
    check("route_hdr_hold", 8'(port_req), 8'h02);
    cfg_cx = 4'h0;
    step(0, 1, BODY, 4'd0, 1, 1);
    step(0, 1, TAIL, 4'd0, 1, 0);
    step(0, 1, HEADER, 4'd6, 0, 0);
    check("busy_we_ignored", 8'(port_req), 8'h02);
    step(0, 1, TAIL, 4'd6, 1, 0);
    cfg_rxy = 8'h3E; cfg_cx = 4'hF;
    step(0, 0, 3'b000, 0, 0, 1);
    step(0, 1, HEADER, 4'd6, 0, 0);
    step(1, 1, BODY, 4'd6, 1, 0);
    check("midpkt_rst_req", 8'(port_req), 8'h00);
    step(0, 1, HEADER, 4'd0, 0, 0);
    check("rst_cfg_revert_W", 8'(port_req), 8'h04);
    step(0, 1, TAIL, 4'd0, 1, 0);
    for (int i = 0; i < 4000; i++) begin
      k = int'($urandom_range(0, 9));
      id = k < 3 ? HEADER : k < 7 ? BODY : k < 9 ? TAIL : 3'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        cfg_rxy = 8'($urandom);
        cfg_cx  = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'hF;
        cfg_cur = 4'($urandom);
        cfg_dr  = 8'($urandom);
        step($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, id, 4'($urandom), $urandom_range(0, 9) < 6, 1);
      end else
        step($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, id, 4'($urandom), $urandom_range(0, 9) < 6, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lbdr_router.md
# lbdr_router

Parametrised Logic-Based Distributed Routing unit, one per router input port, replacing the fixed 2-bit-coordinate minimal LBDR. Decodes the destination of each HEADER flit into a one-hot output-port request. Holds that request for the whole packet until its TAIL flit is consumed. Adds run-time configuration writes, a drop path for unroutable packets, protocol-error flagging and optional deroute support. Sits between the input FIFO and the switch allocator.

## Interface
Parameters:
- COORD_W, 2, bits per X/Y coordinate; address = {y, x}, width 2*COORD_W
- RXY_RST, 8'h3C, routing bits after reset: [0]Rne [1]Rnw [2]Ren [3]Res [4]Rwn [5]Rws [6]Rse [7]Rsw
- CX_RST, 4'hF, connectivity bits after reset: [0]Cn [1]Ce [2]Cw [3]Cs
- CUR_RST, 5, own router address after reset
- DR_RST, 8'h00, deroute codes after reset (only with LBDR_DEROUTE_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  configuration write strobe
- cfg_rxy  in  8  new Rxy
- cfg_cx  in  4  new Cx
- cfg_cur  in  2*COORD_W  new own address
- cfg_dr  in  8  new deroute codes (present only with LBDR_DEROUTE_EN)
- cfg_busy  out  1  state != IDLE; writes are ignored while high
- flit_valid  in  1  FIFO head flit valid (!empty)
- flit_id  in  3  HEADER/BODY/TAIL code
- dst_addr  in  2*COORD_W  destination; meaningful on HEADER only
- flit_pop  in  1  head flit consumed this cycle (allocator grant, or upstream discard while dropping)
- port_req  out  5  one-hot {L,S,W,E,N}
- drop  out  1  current packet is unroutable; upstream discards flits
- proto_err  out  1  one-cycle pulse on a protocol violation

## Operation
- Comparators:
  - N1 = y_dst < y_cur
  - S1 = y_cur < y_dst
  - E1 = x_cur < x_dst
  - W1 = x_dst < x_cur
- Minimal routing:
  - N = (N1·!E1·!W1 | N1·E1·Rne | N1·W1·Rnw)·Cn
  - E = (E1·!N1·!S1 | E1·N1·Ren | E1·S1·Res)·Ce
  - W = (W1·!N1·!S1 | W1·N1·Rwn | W1·S1·Rws)·Cw
  - S = (S1·!E1·!W1 | S1·E1·Rse | S1·W1·Rsw)·Cs
  - L = !N1·!E1·!W1·!S1
- If more than one minimal bit is set, priority is N > E > W > S, so port_req stays one-hot.
- FSM states: IDLE, ROUTE, DROP.
  - IDLE, flit_valid with HEADER:
    - if the result is non-zero, register port_req and go to ROUTE
    - if the result is zero, assert drop and go to DROP
  - IDLE, flit_valid with BODY/TAIL: pulse proto_err and stay in IDLE. The flit is not routed.
  - ROUTE: hold port_req. Exit to IDLE on flit_valid·flit_pop·TAIL. A HEADER seen in ROUTE pulses proto_err and is not re-decoded.
  - DROP: hold drop=1 and port_req=0. Exit to IDLE on flit_valid·flit_pop·TAIL.
- Configuration:
  - cfg_we in IDLE updates all configuration registers at the clock edge.
  - cfg_we while cfg_busy is high is ignored.
  - cfg_we in the same cycle as a HEADER in IDLE: the header is routed with the old configuration, and the new values take effect from the next cycle.
- Unknown flit_id codes behave as BODY.

## Timing
- Reset state: state=IDLE, port_req=0, drop=0, proto_err=0, cfg_busy=0, configuration registers = *_RST.
- Reset mid-packet aborts the packet: outputs return to reset values one edge later.
- Latency:
  - HEADER visible in IDLE at edge k → port_req/drop valid after edge k (one cycle).
  - The header may be popped from the cycle after that edge.
- Exit: a TAIL pop at edge k clears port_req/drop after edge k. A new HEADER can be decoded in the cycle after that edge, giving one idle cycle between packets.
- proto_err is high for exactly the one cycle after the offending edge.
- No back-pressure on this block: flit_pop is an observation only.

## Configuration
- LBDR_DEROUTE_EN defined:
  - cfg_dr and the DR register exist. DR holds a 2-bit port code per primary direction: [1:0]N, [3:2]E, [5:4]W, [7:6]S; codes are 0=N, 1=E, 2=W, 3=S.
  - When the minimal result is zero and L=0:
    - the primary direction is the first set of N1, S1, E1, W1, in that order
    - the DR code for that direction selects the deroute port
    - that port is masked by its Cx bit
  - If the deroute port is also unconnected, the packet goes to DROP.
- LBDR_DEROUTE_EN undefined: no cfg_dr port and no DR register. A zero minimal result always goes to DROP.

## Structure
- Shared package lbdr_pkg:
  - flit codes HEADER=3'b001, BODY=3'b010, TAIL=3'b100
  - port index constants P_N=0, P_E=1, P_W=2, P_S=3, P_L=4
  - state enum lbdr_state_t
  - port-code enum for deroute codes
- One sub-module, lbdr_route_calc: purely combinational decode (comparators, minimal logic, priority one-hot, deroute). The top block holds the FSM and the configuration registers.

## Test plan
- Reset defaults (cur=5), HEADER dst=6 → port_req=00010 (E) one cycle later. BODY pops keep E. TAIL pop → 00000 the next cycle.
- dst=5 → port_req=10000 (L). dst=0 with Rnw=1 (0x3C | 0x02) → N.
- cfg_cx=4'b1101 (Ce=0), dst=6, deroute disabled → drop=1, port_req=0. TAIL pop → drop=0.
- LBDR_DEROUTE_EN, DR[3:2]=3 (E→S), Ce=0, dst=6 → port_req=01000 (S).
- BODY while IDLE → proto_err single pulse, state stays IDLE. HEADER during ROUTE → proto_err, port_req unchanged.
- rst asserted mid-packet → port_req=0 and the configuration reverts to RXY_RST/CX_RST/CUR_RST. cfg_we while busy → configuration unchanged.
